// File: rtl/eth_mdio_master_if.sv
// Command/response bundle for the MDIO management master.
// The requester (framing register file) uses the master modport;
// the MDIO engine uses the slave modport.
interface eth_mdio_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [4:0]  cmd_phy_addr;
    logic [4:0]  cmd_reg_addr;
    logic [15:0] cmd_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    modport master (
        output cmd_valid, cmd_write, cmd_phy_addr, cmd_reg_addr, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_phy_addr, cmd_reg_addr, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface

// File: rtl/eth_mdio_master.sv
// Clause-22 MDIO management master. Takes one read/write command at a time,
// sends a 32-bit preamble plus 32-bit frame on MDC/MDIO, returns read data
// with a single-cycle response strobe.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | cmd_ready high, waiting for a command
// S_PREAMBLE | bit periods 0..31, MDIO driven 1
// S_FRAME    | bit periods 32..63, header/TA/data from the shift register
// S_DONE     | one cycle, rsp_valid pulse, response fields just updated
module eth_mdio_master #(
    parameter int CLK_DIV = 25
) (
    input  logic               msoc_clk,
    input  logic               rst_int,
    eth_mdio_master_if.slave   cmd_if,
    output logic               phy_mdc,
    output logic               phy_mdio_o,
    output logic               phy_mdio_oe,
    input  logic               phy_mdio_i
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREAMBLE,
        S_FRAME,
        S_DONE
    } state_t;

    // Divider counts down from CLK_DIV-1 once per MDC half-period.
    localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);

    state_t      state_q;
    logic [7:0]  div_q;
    logic [5:0]  bit_q;        // bit period 0..63 across preamble and frame
    logic [31:0] sh_q;         // outgoing frame, MSB first
    logic [15:0] rx_q;         // incoming read data, MSB first
    logic        err_q;        // second TA bit sampled high
    logic        wr_q;
    logic        ready_q;
    logic        rsp_valid_q;
    logic [15:0] rsp_rdata_q;
    logic        rsp_err_q;
    logic        mdc_q;
    logic        mdio_o_q;
    logic        mdio_oe_q;

    logic        accept_d;
    logic        div_tc_d;
    logic [5:0]  bit_nxt_d;
    logic [15:0] rx_smp_d;
    logic [31:0] sh_load_d;

    // Handshake, terminal counts and the frame image built from the command.
    always_comb begin
        accept_d  = cmd_if.cmd_valid & ready_q;
        div_tc_d  = (div_q == 8'd0);
        bit_nxt_d = bit_q + 6'd1;
        rx_smp_d  = {rx_q[14:0], phy_mdio_i};
        if (cmd_if.cmd_write)
            sh_load_d = {2'b01, 2'b01, cmd_if.cmd_phy_addr, cmd_if.cmd_reg_addr,
                         2'b10, cmd_if.cmd_wdata};
        else
            sh_load_d = {2'b01, 2'b10, cmd_if.cmd_phy_addr, cmd_if.cmd_reg_addr,
                         2'b11, 16'hFFFF};
    end

    // Sequencer: every output is a register so MDC/MDIO stay glitch-free.
    always_ff @(posedge msoc_clk) begin
        if (rst_int) begin
            state_q     <= S_IDLE;
            div_q       <= 8'd0;
            bit_q       <= 6'd0;
            sh_q        <= 32'd0;
            rx_q        <= 16'd0;
            err_q       <= 1'b0;
            wr_q        <= 1'b0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 16'd0;
            rsp_err_q   <= 1'b0;
            mdc_q       <= 1'b0;
            mdio_o_q    <= 1'b1;
            mdio_oe_q   <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept_d) begin
                        state_q   <= S_PREAMBLE;
                        ready_q   <= 1'b0;
                        div_q     <= DIV_LOAD;
                        bit_q     <= 6'd0;
                        sh_q      <= sh_load_d;
                        wr_q      <= cmd_if.cmd_write;
                        rx_q      <= 16'd0;
                        err_q     <= 1'b0;
                        mdc_q     <= 1'b0;
                        mdio_o_q  <= 1'b1;
                        mdio_oe_q <= 1'b1;
                    end
                end

                S_PREAMBLE, S_FRAME: begin
                    if (!div_tc_d) begin
                        div_q <= div_q - 8'd1;
                    end else begin
                        div_q <= DIV_LOAD;
                        if (!mdc_q) begin
                            mdc_q <= 1'b1;
                        end else begin
                            // Last cycle of the high phase: sample, then open the next bit.
                            mdc_q <= 1'b0;
                            if (state_q == S_FRAME && !wr_q) begin
                                if (bit_q[4:0] == 5'd15)
                                    err_q <= phy_mdio_i;
                                if (bit_q[4])
                                    rx_q <= rx_smp_d;
                            end
                            if (bit_q == 6'd63) begin
                                state_q     <= S_DONE;
                                mdio_o_q    <= 1'b1;
                                mdio_oe_q   <= 1'b0;
                                rsp_valid_q <= 1'b1;
                                rsp_rdata_q <= wr_q ? 16'd0 : rx_smp_d;
                                rsp_err_q   <= wr_q ? 1'b0 : err_q;
                            end else begin
                                bit_q <= bit_nxt_d;
                                if (bit_nxt_d[5]) begin
                                    state_q   <= S_FRAME;
                                    mdio_o_q  <= sh_q[31];
                                    sh_q      <= {sh_q[30:0], 1'b1};
                                    // Reads release the line from the first TA bit on.
                                    mdio_oe_q <= wr_q | (bit_nxt_d[4:0] < 5'd14);
                                end else begin
                                    mdio_o_q  <= 1'b1;
                                    mdio_oe_q <= 1'b1;
                                end
                            end
                        end
                    end
                end

                S_DONE: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end

                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign cmd_if.cmd_ready = ready_q;
    assign cmd_if.busy      = ~ready_q;
    assign cmd_if.rsp_valid = rsp_valid_q;
    assign cmd_if.rsp_rdata = rsp_rdata_q;
    assign cmd_if.rsp_err   = rsp_err_q;
    assign phy_mdc          = mdc_q;
    assign phy_mdio_o       = mdio_o_q;
    assign phy_mdio_oe      = mdio_oe_q;

endmodule

// File: tb/tb_eth_mdio_master.sv
// Bench for eth_mdio_master: default divider instance for frame content,
// timing and reset behaviour; a CLK_DIV=2 instance for minimum-divider timing.
module tb_eth_mdio_master;
    localparam int D  = 25;
    localparam int D2 = 2;

    logic msoc_clk = 1'b0;
    logic rst_int;
    always #5 msoc_clk = ~msoc_clk;

    eth_mdio_master_if if1();
    eth_mdio_master_if if2();

    logic mdc1, mo1, moe1, mi1;
    logic mdc2, mo2, moe2, mi2;
    assign mi2 = 1'b1;

    eth_mdio_master #(.CLK_DIV(D)) u_dut (
        .msoc_clk(msoc_clk), .rst_int(rst_int), .cmd_if(if1),
        .phy_mdc(mdc1), .phy_mdio_o(mo1), .phy_mdio_oe(moe1), .phy_mdio_i(mi1)
    );

    eth_mdio_master #(.CLK_DIV(D2)) u_dut2 (
        .msoc_clk(msoc_clk), .rst_int(rst_int), .cmd_if(if2),
        .phy_mdc(mdc2), .phy_mdio_o(mo2), .phy_mdio_oe(moe2), .phy_mdio_i(mi2)
    );

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    // Line monitor for instance 1: MDIO/OE captured at each MDC rise.
    int   rise_total = 0;
    logic mon_o  [0:2047];
    logic mon_oe [0:2047];
    logic mdc1_prev = 1'b0;
    logic mo1_prev  = 1'b1;
    int   o_viol    = 0;
    int   rsp_total = 0;

    // PHY model state.
    int          phy_mode = 0;      // 0 absent (pull-up), 1 good TA, 2 TA2 left high
    int          phy_base = 0;
    logic [15:0] phy_data = 16'd0;
    int          phy_idx, phy_f;
    logic [3:0]  phy_bi;

    // Instance 2 MDC timing monitor.
    logic mdc2_prev  = 1'b0;
    int   last_rise2 = 0;
    int   rises2     = 0;
    int   mdc2_bad   = 0;

    always @(posedge msoc_clk) cyc <= cyc + 1;

    always @(negedge msoc_clk) begin
        mdc1_prev <= mdc1;
        mo1_prev  <= mo1;
        if (mdc1 && !mdc1_prev) begin
            mon_o[rise_total[10:0]]  <= mo1;
            mon_oe[rise_total[10:0]] <= moe1;
            rise_total <= rise_total + 1;
        end
        if (mdc1 && (mo1 !== mo1_prev)) o_viol <= o_viol + 1;
        if (if1.rsp_valid) rsp_total <= rsp_total + 1;
    end

    always @(negedge msoc_clk) begin
        mdc2_prev <= mdc2;
        if (mdc2 && !mdc2_prev) begin
            if (rises2 > 0 && (cyc - last_rise2) != 2 * D2) mdc2_bad <= mdc2_bad + 1;
            last_rise2 <= cyc;
            rises2     <= rises2 + 1;
        end
        if (!mdc2 && mdc2_prev && (cyc - last_rise2) != D2) mdc2_bad <= mdc2_bad + 1;
    end

    // PHY drives bit k for the whole of bit period k (index from MDC rises).
    always_comb begin
        mi1     = 1'b1;
        phy_idx = (mdc1 ? rise_total - 1 : rise_total) - phy_base;
        phy_f   = phy_idx - 32;
        phy_bi  = 4'(31 - phy_f);
        if (phy_mode != 0) begin
            if (phy_f == 15)
                mi1 = (phy_mode == 2);
            else if (phy_f >= 16 && phy_f <= 31)
                mi1 = phy_data[phy_bi];
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present a command (caller is at a negedge) and wait for its accept.
    task automatic issue(input bit wr, input logic [4:0] pa, input logic [4:0] ra,
                         input logic [15:0] wd, input int mode, input logic [15:0] pdata,
                         input bit hold, output int t, output int base);
        int n;
        if1.cmd_write    = wr;
        if1.cmd_phy_addr = pa;
        if1.cmd_reg_addr = ra;
        if1.cmd_wdata    = wd;
        if1.cmd_valid    = 1'b1;
        n = 0;
        while (if1.cmd_ready !== 1'b1 && n < 8000) begin
            @(negedge msoc_clk);
            n++;
        end
        check("accept_seen", 64'(if1.cmd_ready), 64'd1);
        t = cyc;
        phy_mode = mode;
        phy_data = pdata;
        @(negedge msoc_clk);
        base     = rise_total;
        phy_base = base;
        if (!hold) if1.cmd_valid = 1'b0;
        check("start_ready", 64'(if1.cmd_ready), 64'd0);
        check("start_busy",  64'(if1.busy),      64'd1);
        check("start_mdc",   64'(mdc1),          64'd0);
        check("start_oe",    64'(moe1),          64'd1);
        check("start_o",     64'(mo1),           64'd1);
    endtask

    // Wait for the response and compare the whole transaction with the model.
    task automatic complete(input bit wr, input logic [4:0] pa, input logic [4:0] ra,
                            input logic [15:0] wd, input int mode, input logic [15:0] pdata,
                            input int t, input int base, input bit scramble, output int tdone);
        int n, idx;
        logic [63:0] fr_exp, oe_exp, fr_obs, oe_obs;
        logic [15:0] rd_exp;
        logic        err_exp;
        n = 0;
        while (if1.rsp_valid !== 1'b1 && n < 8000) begin
            if (scramble) begin
                if1.cmd_write    = 1'($urandom);
                if1.cmd_phy_addr = 5'($urandom);
                if1.cmd_reg_addr = 5'($urandom);
                if1.cmd_wdata    = 16'($urandom);
            end
            @(negedge msoc_clk);
            n++;
        end
        tdone = cyc;
        check("done_cycle", 64'(cyc), 64'(t + 1 + 128 * D));

        fr_exp = {32'hFFFF_FFFF, 2'b01, (wr ? 2'b01 : 2'b10), pa, ra,
                  (wr ? 2'b10 : 2'b11), (wr ? wd : 16'hFFFF)};
        oe_exp = wr ? {64{1'b1}} : {{46{1'b1}}, 18'd0};
        if (wr) begin
            rd_exp = 16'd0;      err_exp = 1'b0;
        end else if (mode == 0) begin
            rd_exp = 16'hFFFF;   err_exp = 1'b1;
        end else begin
            rd_exp = pdata;      err_exp = (mode == 2);
        end

        check("done_mdc",   64'(mdc1),          64'd0);
        check("done_oe",    64'(moe1),          64'd0);
        check("done_o",     64'(mo1),           64'd1);
        check("done_ready", 64'(if1.cmd_ready), 64'd0);
        check("done_rdata", 64'(if1.rsp_rdata), 64'(rd_exp));
        check("done_err",   64'(if1.rsp_err),   64'(err_exp));

        for (int k = 0; k < 64; k++) begin
            idx = base + k;
            fr_obs[63 - k] = mon_o[idx[10:0]];
            oe_obs[63 - k] = mon_oe[idx[10:0]];
        end
        check("frame_bits", fr_obs, fr_exp);
        check("frame_oe",   oe_obs, oe_exp);
        check("mdc_rises",  64'(rise_total - base), 64'd64);

        @(negedge msoc_clk);
        check("post_rsp_valid", 64'(if1.rsp_valid), 64'd0);
        check("post_ready",     64'(if1.cmd_ready), 64'd1);
        check("post_rdata",     64'(if1.rsp_rdata), 64'(rd_exp));
        check("post_err",       64'(if1.rsp_err),   64'(err_exp));
    endtask

    initial begin
        int t, b, td, tda, n, rc;
        logic [4:0]  pa, ra, pb, rb;
        logic [15:0] da, db;

        rst_int = 1'b1;
        if1.cmd_valid = 1'b0; if1.cmd_write = 1'b0; if1.cmd_phy_addr = 5'd0;
        if1.cmd_reg_addr = 5'd0; if1.cmd_wdata = 16'd0;
        if2.cmd_valid = 1'b0; if2.cmd_write = 1'b0; if2.cmd_phy_addr = 5'd0;
        if2.cmd_reg_addr = 5'd0; if2.cmd_wdata = 16'd0;
        repeat (3) @(negedge msoc_clk);
        check("rst_ready",     64'(if1.cmd_ready), 64'd1);
        check("rst_busy",      64'(if1.busy),      64'd0);
        check("rst_rsp_valid", 64'(if1.rsp_valid), 64'd0);
        check("rst_rdata",     64'(if1.rsp_rdata), 64'd0);
        check("rst_err",       64'(if1.rsp_err),   64'd0);
        check("rst_mdc",       64'(mdc1),          64'd0);
        check("rst_o",         64'(mo1),           64'd1);
        check("rst_oe",        64'(moe1),          64'd0);
        rst_int = 1'b0;
        @(negedge msoc_clk);
        check("idle_ready", 64'(if1.cmd_ready), 64'd1);

        // Directed write: phy 1, reg 0, data 0x1140.
        issue(1'b1, 5'd1, 5'd0, 16'h1140, 0, 16'd0, 1'b0, t, b);
        complete(1'b1, 5'd1, 5'd0, 16'h1140, 0, 16'd0, t, b, 1'b1, td);

        // Directed read with PHY returning 0x796D.
        issue(1'b0, 5'd3, 5'd2, 16'h0000, 1, 16'h796D, 1'b0, t, b);
        complete(1'b0, 5'd3, 5'd2, 16'h0000, 1, 16'h796D, t, b, 1'b1, td);

        // Random read where the PHY leaves TA2 high: error plus captured data.
        pa = 5'($urandom); ra = 5'($urandom); da = 16'($urandom);
        issue(1'b0, pa, ra, 16'($urandom), 2, da, 1'b0, t, b);
        complete(1'b0, pa, ra, 16'd0, 2, da, t, b, 1'b1, td);

        // Random write.
        pa = 5'($urandom); ra = 5'($urandom); da = 16'($urandom);
        issue(1'b1, pa, ra, da, 0, 16'd0, 1'b0, t, b);
        complete(1'b1, pa, ra, da, 0, 16'd0, t, b, 1'b1, td);

        // Two queued commands with cmd_valid held high throughout.
        pa = 5'($urandom); ra = 5'($urandom); da = 16'($urandom);
        pb = 5'($urandom); rb = 5'($urandom); db = 16'($urandom);
        issue(1'b0, pa, ra, 16'd0, 1, da, 1'b1, t, b);
        if1.cmd_write = 1'b1; if1.cmd_phy_addr = pb; if1.cmd_reg_addr = rb; if1.cmd_wdata = db;
        complete(1'b0, pa, ra, 16'd0, 1, da, t, b, 1'b0, tda);
        issue(1'b1, pb, rb, db, 0, 16'd0, 1'b0, t, b);
        check("held_accept_gap", 64'(t), 64'(tda + 1));
        complete(1'b1, pb, rb, db, 0, 16'd0, t, b, 1'b1, td);

        // Read with no PHY: pull-up only.
        pa = 5'($urandom); ra = 5'($urandom);
        issue(1'b0, pa, ra, 16'd0, 0, 16'd0, 1'b0, t, b);
        complete(1'b0, pa, ra, 16'd0, 0, 16'd0, t, b, 1'b1, td);

        // Reset during header bit 5 of a write.
        pa = 5'($urandom); ra = 5'($urandom); da = 16'($urandom);
        issue(1'b1, pa, ra, da, 0, 16'd0, 1'b0, t, b);
        n = 0;
        while ((rise_total - b) < 38 && n < 8000) begin
            @(negedge msoc_clk);
            n++;
        end
        check("reached_hdr5", 64'((rise_total - b) >= 38), 64'd1);
        rst_int = 1'b1;
        @(negedge msoc_clk);
        rst_int = 1'b0;
        rc = rsp_total;
        check("abort_mdc",   64'(mdc1),          64'd0);
        check("abort_oe",    64'(moe1),          64'd0);
        check("abort_o",     64'(mo1),           64'd1);
        check("abort_ready", 64'(if1.cmd_ready), 64'd1);
        check("abort_busy",  64'(if1.busy),      64'd0);
        check("abort_rsp",   64'(if1.rsp_valid), 64'd0);
        check("abort_rdata", 64'(if1.rsp_rdata), 64'd0);
        check("abort_err",   64'(if1.rsp_err),   64'd0);
        repeat (128 * D + 10) @(negedge msoc_clk);
        check("abort_no_rsp", 64'(rsp_total), 64'(rc));
        check("abort_idle",   64'(if1.cmd_ready), 64'd1);
        check("o_stable_high_phase", 64'(o_viol), 64'd0);

        // Minimum divider instance.
        if2.cmd_write = 1'b1; if2.cmd_phy_addr = 5'($urandom);
        if2.cmd_reg_addr = 5'($urandom); if2.cmd_wdata = 16'($urandom);
        if2.cmd_valid = 1'b1;
        n = 0;
        while (if2.cmd_ready !== 1'b1 && n < 1000) begin
            @(negedge msoc_clk);
            n++;
        end
        t = cyc;
        @(negedge msoc_clk);
        if2.cmd_valid = 1'b0;
        n = 0;
        while (if2.rsp_valid !== 1'b1 && n < 1000) begin
            @(negedge msoc_clk);
            n++;
        end
        check("div2_done_cycle", 64'(cyc), 64'(t + 257));
        check("div2_rises",      64'(rises2),   64'd64);
        check("div2_mdc_timing", 64'(mdc2_bad), 64'd0);
        check("div2_rdata",      64'(if2.rsp_rdata), 64'd0);
        check("div2_err",        64'(if2.rsp_err),   64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/eth_mdio_master.md
# eth_mdio_master

Hardware MDIO (IEEE 802.3 clause 22) management master for the RGMII Ethernet PHY, replacing software bit-banging of the MDIO/MDC control register in the framing block. It accepts single read/write commands over a valid/ready interface in the `msoc_clk` domain, serialises the 64-bit-period management frame on MDC/MDIO, and returns read data with a one-cycle response strobe. It sits between the framing register file and the PHY MDIO pins.

## Interface
- `CLK_DIV`, 25, msoc_clk cycles per MDC half-period; legal range 2..255. MDC period is 2*CLK_DIV.
- `msoc_clk` in 1: the only clock.
- `rst_int` in 1: reset, synchronous and active-high.
- `cmd_valid` in 1: command request; held until accepted.
- `cmd_ready` out 1: high when idle; the command transfers on `cmd_valid & cmd_ready`.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_phy_addr` in 5: PHY address.
- `cmd_reg_addr` in 5: register address.
- `cmd_wdata` in 16: write data; ignored for reads.
- `rsp_valid` out 1: one-cycle pulse when a transaction completes.
- `rsp_rdata` out 16: read data; 0 for writes. Held until the next `rsp_valid`.
- `rsp_err` out 1: read turnaround not driven low by the PHY. Held like `rsp_rdata`.
- `busy` out 1: equals `~cmd_ready`.
- `phy_mdc` out 1: management clock.
- `phy_mdio_o` out 1: MDIO output value.
- `phy_mdio_oe` out 1: MDIO output enable.
- `phy_mdio_i` in 1: MDIO pin input. The board has an external pull-up.

## Operation
- **Command capture.** On acceptance, latch `cmd_*` into a 32-bit shift register: {2'b01, op, phy_addr, reg_addr, ta, data}.
  - Write: op = 2'b01, ta = 2'b10, data = `cmd_wdata`.
  - Read: op = 2'b10, ta = 2'b11 (not driven), data = 16'hFFFF (not driven).
- **States.**
  - IDLE → PREAMBLE on accept.
  - PREAMBLE: 32 bit periods, MDIO driven 1.
  - FRAME: 32 bit periods, header MSB first, then TA, then data.
  - FRAME → DONE after the 32nd bit.
  - DONE: one cycle. Pulses `rsp_valid`, then returns to IDLE.
- **Bit period.** 2*CLK_DIV cycles. MDC is low for the first CLK_DIV cycles and high for the last CLK_DIV. `phy_mdio_o` changes only on the first cycle of a bit period, while MDC is low.
- **Output enable.**
  - `phy_mdio_oe` = 1 through PREAMBLE and header bits 0..13.
  - Writes keep `oe` = 1 through TA and data.
  - Reads drop `oe` to 0 from the first TA bit through the end of the frame.
- **Read sampling.** Sample `phy_mdio_i` on the last cycle of each bit's high phase.
  - The 2nd TA bit sampled as 1 sets `rsp_err` = 1.
  - The 16 data bits shift in MSB first into `rsp_rdata`. Data is captured even when `rsp_err` = 1.
- **Ignored inputs.** `cmd_*` are ignored while busy. A bit counter (6 bits) and a divider counter (8 bits) sequence all activity.

## Timing
- **Reset values.**
  - `cmd_ready` = 1, `busy` = 0, `rsp_valid` = 0.
  - `rsp_rdata` = 0, `rsp_err` = 0.
  - `phy_mdc` = 0, `phy_mdio_o` = 1, `phy_mdio_oe` = 0.
- **Frame start.** Handshake on the edge ending cycle T. The first preamble bit period starts at cycle T+1: MDC low, `oe` = 1, `o` = 1. `cmd_ready` is 0 from T+1.
- **Frame end.** The last bit period ends at cycle T+64*2*CLK_DIV. DONE is cycle T+1+128*CLK_DIV (T+3201 at default).
  - In DONE: `rsp_valid` = 1, `phy_mdc` = 0, `phy_mdio_oe` = 0, `phy_mdio_o` = 1, `cmd_ready` = 0.
  - `cmd_ready` returns to 1 at cycle T+2+128*CLK_DIV.
- **Back-to-back commands.** A new command can be accepted in the first IDLE cycle, so the minimum spacing between accepts is 128*CLK_DIV+2 cycles.
- **Response fields.** `rsp_rdata` and `rsp_err` update in the DONE cycle and are stable while `rsp_valid` = 1.
- **Reset mid-transaction.** Abort the transaction. All outputs take their reset values in the next cycle. No `rsp_valid` is issued.

## Test plan
- **Write.** phy 1, reg 0, data 0x1140 → the 64 bits on MDIO, sampled at MDC rising edges, are 32×1, 0101, 00001, 00000, 10, 0001000101000000. `oe` = 1 throughout. `rsp_valid` at T+3201, `rsp_rdata` = 0, `rsp_err` = 0.
- **Read with PHY model.** phy 3, reg 2, PHY model drives TA2 = 0 and data 0x796D → `oe` falls at TA start, `rsp_rdata` = 0x796D, `rsp_err` = 0.
- **Read, no PHY.** `phy_mdio_i` tied 1 → `rsp_err` = 1, `rsp_rdata` = 0xFFFF.
- **Held commands.** `cmd_valid` held high with two queued commands → the second accept occurs exactly one cycle after the first `rsp_valid`. No `cmd_*` change during busy affects the frame.
- **Reset mid-frame.** Assert `rst_int` for 1 cycle at header bit 5 → the next cycle shows `mdc` = 0, `oe` = 0, `o` = 1, `cmd_ready` = 1, and no `rsp_valid`.
- **Minimum divider.** CLK_DIV = 2 → MDC period is 4 cycles with a 50% duty cycle, and the transaction length is 257 cycles from accept to DONE.
